// File: rtl/l0_skew_feeder.sv
// West-edge staging buffer for the systolic array: one FIFO per row lane,
// drained with a one-cycle-per-row diagonal skew and a matching per-row instruction.
module l0_skew_feeder #(
  parameter int row   = 8,
  parameter int bw    = 4,
  parameter int depth = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr,
  input  logic [row*bw-1:0]   in,
  input  logic                rd,
  input  logic [1:0]          inst_in,
  output logic [row*bw-1:0]   out,
  output logic [2*row-1:0]    inst_out,
  output logic [row-1:0]      out_valid,
  output logic                full,
  output logic                empty,
  output logic                ready
);

  localparam int aw = $clog2(depth);
  localparam logic [aw-1:0] ptr_one  = aw'(1);
  localparam logic [aw:0]   cnt_one  = (aw+1)'(1);
  localparam logic [aw:0]   cnt_full = (aw+1)'(depth);

  // {request, inst[1:0]}
  typedef logic [2:0] req_t;

  logic [bw-1:0] mem [row][depth];
  logic [aw-1:0] wptr [row];
  logic [aw-1:0] rptr [row];
  logic [aw:0]   cnt [row];
  req_t          skew_q [row-1];
  req_t          req [row];
  logic [row-1:0] pop;
  logic [row-1:0] pop_q;
  logic [bw-1:0] dat_q [row];
  logic [1:0]    ins_q [row];
  logic          push;

  always_comb begin
    full  = (cnt[row-1] == cnt_full);
    empty = (cnt[0] == '0);
    ready = !full;
    push  = wr && !full;
  end

  // Lane 0 sees rd directly; lane i sees it after i register stages.
  always_comb begin
    req[0] = {rd, inst_in};
    for (int unsigned i = 1; i < row; i++) begin
      req[i] = skew_q[i-1];
    end
    pop = '0;
    for (int unsigned i = 0; i < row; i++) begin
      pop[i] = req[i][2] && (cnt[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int unsigned i = 0; i < row; i++) begin
        mem[i][wptr[i]] <= in[i*bw +: bw];
      end
    end
  end

  // The pop is decided on the edge the request reaches the lane (using the
  // count before any same-edge write) and presented one edge later, so a
  // write in the same cycle as a request is never bypassed to the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < row; i++) begin
        wptr[i]  <= '0;
        rptr[i]  <= '0;
        cnt[i]   <= '0;
        dat_q[i] <= '0;
        ins_q[i] <= '0;
      end
      for (int unsigned i = 0; i < row - 1; i++) begin
        skew_q[i] <= '0;
      end
      pop_q     <= '0;
      out       <= '0;
      inst_out  <= '0;
      out_valid <= '0;
    end else begin
      skew_q[0] <= req[0];
      for (int unsigned i = 1; i < row - 1; i++) begin
        skew_q[i] <= skew_q[i-1];
      end
      for (int unsigned i = 0; i < row; i++) begin
        if (push) begin
          wptr[i] <= wptr[i] + ptr_one;
        end
        if (pop[i]) begin
          rptr[i]  <= rptr[i] + ptr_one;
          dat_q[i] <= mem[i][rptr[i]];
        end
        unique case ({push, pop[i]})
          2'b10:   cnt[i] <= cnt[i] + cnt_one;
          2'b01:   cnt[i] <= cnt[i] - cnt_one;
          default: cnt[i] <= cnt[i];
        endcase
        ins_q[i] <= pop[i] ? req[i][1:0] : 2'b00;
        if (pop_q[i]) begin
          out[i*bw +: bw] <= dat_q[i];
        end
        inst_out[2*i +: 2] <= ins_q[i];
      end
      pop_q     <= pop;
      out_valid <= pop_q;
    end
  end

endmodule

// File: tb/tb_l0_skew_feeder.sv
// Directed bench for l0_skew_feeder: a per-lane FIFO reference feeds a
// per-lane queue of expected pops, compared cycle by cycle on the falling edge.
module tb_l0_skew_feeder;

  localparam int ROW   = 8;
  localparam int BW    = 4;
  localparam int DEPTH = 64;

  logic                clk = 1'b0;
  logic                reset;
  logic                wr;
  logic [ROW*BW-1:0]   in_vec;
  logic                rd;
  logic [1:0]          inst_in;
  logic [ROW*BW-1:0]   out_vec;
  logic [2*ROW-1:0]    inst_out;
  logic [ROW-1:0]      out_valid;
  logic                full;
  logic                empty;
  logic                ready;

  l0_skew_feeder #(.row(ROW), .bw(BW), .depth(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr),
    .in        (in_vec),
    .rd        (rd),
    .inst_in   (inst_in),
    .out       (out_vec),
    .inst_out  (inst_out),
    .out_valid (out_valid),
    .full      (full),
    .empty     (empty),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [BW-1:0] d; int w; } ent_t;
  typedef struct { int c; logic [BW-1:0] d; logic [1:0] inst; } exp_t;

  ent_t          mq [ROW][$];
  exp_t          eq [ROW][$];
  logic [BW-1:0] last_out [ROW];
  int            cyc = 0;
  int            comps = 0;
  int            errs = 0;
  logic          mon_on = 1'b0;
  exp_t          mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    comps++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on && !reset) begin
      for (int i = 0; i < ROW; i++) begin
        if (eq[i].size() > 0 && eq[i][0].c == cyc) begin
          mon_e = eq[i].pop_front();
          check($sformatf("valid_l%0d", i), 32'(out_valid[i]), 32'd1);
          check($sformatf("data_l%0d", i), 32'(out_vec[i*BW +: BW]), 32'(mon_e.d));
          check($sformatf("inst_l%0d", i), 32'(inst_out[2*i +: 2]), 32'(mon_e.inst));
          last_out[i] = mon_e.d;
        end else begin
          check($sformatf("idle_valid_l%0d", i), 32'(out_valid[i]), 32'd0);
          check($sformatf("idle_inst_l%0d", i), 32'(inst_out[2*i +: 2]), 32'd0);
          check($sformatf("hold_data_l%0d", i), 32'(out_vec[i*BW +: BW]), 32'(last_out[i]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  function automatic logic [ROW*BW-1:0] mk(input int k);
    logic [ROW*BW-1:0] v;
    for (int i = 0; i < ROW; i++) v[i*BW +: BW] = 4'((k + i + k / 16) % 16);
    return v;
  endfunction

  // One clock of stimulus; the reference is updated for the edge that samples it.
  task automatic step(input logic w, input logic [ROW*BW-1:0] v, input logic r,
                      input logic [1:0] ins);
    int   e;
    ent_t ent;
    e = cyc + 1;
    wr = w; in_vec = v; rd = r; inst_in = ins;
    if (w && mq[ROW-1].size() < DEPTH) begin
      for (int i = 0; i < ROW; i++) begin
        ent.d = v[i*BW +: BW];
        ent.w = e;
        mq[i].push_back(ent);
      end
    end
    if (r) begin
      for (int i = 0; i < ROW; i++) begin
        if (mq[i].size() > 0 && mq[i][0].w < e + i) begin
          ent = mq[i].pop_front();
          eq[i].push_back('{c: e + 1 + i, d: ent.d, inst: ins});
        end
      end
    end
    tick();
    wr = 1'b0; rd = 1'b0; in_vec = '0; inst_in = 2'b00;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < ROW; i++) begin
      eq[i].delete();
      mq[i].delete();
      last_out[i] = '0;
    end
    idle(n);
    reset = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic e_empty, input logic e_full);
    check({tag, "_empty"}, 32'(empty), 32'(e_empty));
    check({tag, "_full"}, 32'(full), 32'(e_full));
    check({tag, "_ready"}, 32'(ready), 32'(!e_full));
  endtask

  initial begin
    wr = 1'b0; rd = 1'b0; in_vec = '0; inst_in = 2'b00;
    do_reset(3);
    mon_on = 1'b1;

    // Reset then idle
    for (int n = 0; n < 10; n++) begin
      check_flags("reset_idle", 1'b1, 1'b0);
      tick();
    end

    // Three vectors, three back-to-back waves
    for (int k = 0; k < 3; k++) step(1'b1, mk(k), 1'b0, 2'b00);
    check_flags("three_loaded", 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1, 2'b10);
    idle(ROW + 4);
    check_flags("three_drained", 1'b1, 1'b0);

    // Fill to depth, overflow write dropped, drain in order across the wrap
    for (int k = 0; k < DEPTH; k++) step(1'b1, mk(k + 5), 1'b0, 2'b00);
    check_flags("filled", 1'b0, 1'b1);
    step(1'b1, 32'hA5A5_A5A5, 1'b0, 2'b00);
    check_flags("overflow", 1'b0, 1'b1);
    for (int k = 0; k < DEPTH; k++) step(1'b0, '0, 1'b1, 2'b10);
    idle(ROW + 4);
    check_flags("full_drained", 1'b1, 1'b0);

    // Read of an empty FIFO, then a normal write and read
    step(1'b0, '0, 1'b1, 2'b01);
    idle(ROW + 4);
    check_flags("empty_rd", 1'b1, 1'b0);
    step(1'b1, mk(7), 1'b0, 2'b00);
    step(1'b0, '0, 1'b1, 2'b01);
    idle(ROW + 4);
    check_flags("after_empty_rd", 1'b1, 1'b0);

    // Same-cycle write and read on an empty FIFO: no bypass into lane 0
    step(1'b1, mk(9), 1'b1, 2'b10);
    idle(ROW + 4);
    check_flags("same_cycle", 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 2'b10);
    idle(ROW + 4);
    check_flags("same_cycle_drained", 1'b1, 1'b0);

    // Reset part way through a three-wave drain
    for (int k = 0; k < 3; k++) step(1'b1, mk(k + 11), 1'b0, 2'b00);
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1, 2'b10);
    tick();
    do_reset(2);
    idle(ROW + 4);
    check_flags("mid_reset", 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 2'b10);
    idle(ROW + 4);
    check_flags("mid_reset_rd", 1'b1, 1'b0);

    for (int i = 0; i < ROW; i++) begin
      check($sformatf("pending_l%0d", i), 32'(eq[i].size()), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
    $finish;
  end

endmodule
